// File: rtl/sgdmac_desc_sched.sv
// sgdmac_desc_sched: in-order descriptor queue that launches the read/write engine pair and retires on both done.
// Optional RUN watchdog with sticky ERR state when SGDMAC_SCHED_TIMEOUT_EN is defined.
module sgdmac_desc_sched #(
    parameter int DESC_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          desc_push_i,
    input  logic [31:0]                   desc_src_i,
    input  logic [31:0]                   desc_dst_i,
    input  logic [15:0]                   desc_len_i,
    output logic                          desc_full_o,
    output logic [$clog2(DESC_DEPTH):0]   desc_cnt_o,
    output logic                          ovf_o,
    output logic                          rd_start_o,
    output logic [47:0]                   rd_cmd_o,
    input  logic                          rd_done_i,
    output logic                          wr_start_o,
    output logic [47:0]                   wr_cmd_o,
    input  logic                          wr_done_i,
    output logic                          busy_o,
    output logic                          irq_o,
    input  logic                          irq_clr_i,
    output logic [15:0]                   cmpl_cnt_o,
    output logic                          err_o
);
    localparam int AW = $clog2(DESC_DEPTH);

    if (DESC_DEPTH < 2 || (DESC_DEPTH & (DESC_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("sgdmac_desc_sched: DESC_DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 2");
    end

    typedef enum logic [2:0] {
        IDLE, LAUNCH, GUARD, RUN, RETIRE
`ifdef SGDMAC_SCHED_TIMEOUT_EN
        , ERR
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [AW:0]   wr_ptr_q, rd_ptr_q, cnt;
    logic [79:0]   mem_q [DESC_DEPTH];
    logic [79:0]   head;
    logic [47:0]   rd_cmd_q, rd_cmd_d, wr_cmd_q, wr_cmd_d;
    logic          start_q, start_d;
    logic          rd_fin_q, rd_fin_d, wr_fin_q, wr_fin_d;
    logic [15:0]   cmpl_q, cmpl_d;
    logic          irq_q, irq_d, ovf_q, ovf_d;
    logic          full, empty, push_ok, pop;
`ifdef SGDMAC_SCHED_TIMEOUT_EN
    logic [31:0]   wd_q, wd_d;
    logic          err_q, err_d;
`endif

    assign cnt     = wr_ptr_q - rd_ptr_q;
    assign full    = cnt == (AW + 1)'(DESC_DEPTH);
    assign empty   = cnt == '0;
    assign push_ok = desc_push_i & ~full;
    assign pop     = state_q == RETIRE;
    assign head    = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= {desc_src_i, desc_dst_i, desc_len_i & 16'hfffc};
    end

    always_comb begin
        state_d  = state_q;
        rd_cmd_d = rd_cmd_q;
        wr_cmd_d = wr_cmd_q;
        start_d  = 1'b0;
        rd_fin_d = rd_fin_q;
        wr_fin_d = wr_fin_q;
        cmpl_d   = cmpl_q;
        irq_d    = irq_q & ~irq_clr_i;
        ovf_d    = (ovf_q & ~irq_clr_i) | (desc_push_i & full);
`ifdef SGDMAC_SCHED_TIMEOUT_EN
        wd_d     = wd_q;
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: if (!empty && rd_done_i && wr_done_i) begin
                state_d  = LAUNCH;
                rd_cmd_d = {head[79:48], head[15:0]};
                wr_cmd_d = {head[47:16], head[15:0]};
                start_d  = |head[15:0];
            end
            LAUNCH: state_d = |rd_cmd_q[15:0] ? GUARD : RETIRE;
            GUARD: begin
                state_d  = RUN;
                rd_fin_d = 1'b0;
                wr_fin_d = 1'b0;
`ifdef SGDMAC_SCHED_TIMEOUT_EN
                wd_d     = '0;
`endif
            end
            RUN: begin
                rd_fin_d = rd_fin_q | rd_done_i;
                wr_fin_d = wr_fin_q | wr_done_i;
                if (rd_fin_d && wr_fin_d) state_d = RETIRE;
`ifdef SGDMAC_SCHED_TIMEOUT_EN
                else if (wd_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end else wd_d = wd_q + 32'd1;
`endif
            end
            RETIRE: begin
                state_d = IDLE;
                cmpl_d  = cmpl_q + 16'd1;
                irq_d   = 1'b1;
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rd_cmd_q <= '0;
            wr_cmd_q <= '0;
            start_q  <= 1'b0;
            rd_fin_q <= 1'b0;
            wr_fin_q <= 1'b0;
            cmpl_q   <= '0;
            irq_q    <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef SGDMAC_SCHED_TIMEOUT_EN
            wd_q     <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_q + (AW + 1)'(push_ok);
            rd_ptr_q <= rd_ptr_q + (AW + 1)'(pop);
            rd_cmd_q <= rd_cmd_d;
            wr_cmd_q <= wr_cmd_d;
            start_q  <= start_d;
            rd_fin_q <= rd_fin_d;
            wr_fin_q <= wr_fin_d;
            cmpl_q   <= cmpl_d;
            irq_q    <= irq_d;
            ovf_q    <= ovf_d;
`ifdef SGDMAC_SCHED_TIMEOUT_EN
            wd_q     <= wd_d;
            err_q    <= err_d;
`endif
        end
    end

    assign desc_full_o = full;
    assign desc_cnt_o  = cnt;
    assign ovf_o       = ovf_q;
    assign rd_start_o  = start_q;
    assign wr_start_o  = start_q;
    assign rd_cmd_o    = rd_cmd_q;
    assign wr_cmd_o    = wr_cmd_q;
    assign busy_o      = (state_q != IDLE) | ~empty;
    assign irq_o       = irq_q;
    assign cmpl_cnt_o  = cmpl_q;
`ifdef SGDMAC_SCHED_TIMEOUT_EN
    assign err_o       = err_q;
`else
    assign err_o       = 1'b0;
`endif
endmodule

// File: tb/tb_sgdmac_desc_sched.sv
// tb_sgdmac_desc_sched: directed bench for the descriptor scheduler (DESC_DEPTH=4, TIMEOUT_CYCLES=16).
module tb_sgdmac_desc_sched;
    logic        clk = 1'b0, rst = 1'b1;
    logic        desc_push_i = 1'b0, rd_done_i = 1'b1, wr_done_i = 1'b1, irq_clr_i = 1'b0;
    logic [31:0] desc_src_i = '0, desc_dst_i = '0;
    logic [15:0] desc_len_i = '0;
    logic        desc_full_o, ovf_o, rd_start_o, wr_start_o, busy_o, irq_o, err_o;
    logic [2:0]  desc_cnt_o;
    logic [47:0] rd_cmd_o, wr_cmd_o;
    logic [15:0] cmpl_cnt_o;
    int          passed = 0, total = 0, exp_cmpl = 0;

    always #5 clk = ~clk;

    sgdmac_desc_sched #(.DESC_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .desc_push_i(desc_push_i), .desc_src_i(desc_src_i),
        .desc_dst_i(desc_dst_i), .desc_len_i(desc_len_i), .desc_full_o(desc_full_o),
        .desc_cnt_o(desc_cnt_o), .ovf_o(ovf_o), .rd_start_o(rd_start_o), .rd_cmd_o(rd_cmd_o),
        .rd_done_i(rd_done_i), .wr_start_o(wr_start_o), .wr_cmd_o(wr_cmd_o), .wr_done_i(wr_done_i),
        .busy_o(busy_o), .irq_o(irq_o), .irq_clr_i(irq_clr_i), .cmpl_cnt_o(cmpl_cnt_o), .err_o(err_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
        desc_push_i = 1'b1;
        desc_src_i  = s;
        desc_dst_i  = d;
        desc_len_i  = l;
        tick();
        desc_push_i = 1'b0;
    endtask

    task automatic clear_irq();
        irq_clr_i = 1'b1;
        tick();
        irq_clr_i = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        total++;
        if ({rd_start_o, wr_start_o, desc_full_o, ovf_o, busy_o, irq_o, err_o} !== 7'b0)
            $display("FAIL %s_flags: got %b want 0000000", tag,
                     {rd_start_o, wr_start_o, desc_full_o, ovf_o, busy_o, irq_o, err_o});
        else passed++;
        total++;
        if (rd_cmd_o !== 48'h0 || wr_cmd_o !== 48'h0)
            $display("FAIL %s_cmd: got rd=%h wr=%h want 0", tag, rd_cmd_o, wr_cmd_o);
        else passed++;
        total++;
        if (desc_cnt_o !== 3'd0 || cmpl_cnt_o !== 16'd0)
            $display("FAIL %s_cnt: got cnt=%0d cmpl=%0d want 0", tag, desc_cnt_o, cmpl_cnt_o);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_all_zero("reset");
    endtask

    task automatic test_single();
        int n;
        rd_done_i = 1'b1;
        wr_done_i = 1'b1;
        push(32'h1000, 32'h8000, 16'h0100);
        total++;
        if (rd_start_o !== 1'b0 || desc_cnt_o !== 3'd1)
            $display("FAIL single_latency1: got start=%b cnt=%0d want 0/1", rd_start_o, desc_cnt_o);
        else passed++;
        tick();
        total++;
        if ({rd_start_o, wr_start_o} !== 2'b11)
            $display("FAIL single_start: got %b want 11", {rd_start_o, wr_start_o});
        else passed++;
        total++;
        if (rd_cmd_o !== 48'h00001000_0100 || wr_cmd_o !== 48'h00008000_0100)
            $display("FAIL single_cmd: got rd=%h wr=%h want 000010000100/000080000100", rd_cmd_o, wr_cmd_o);
        else passed++;
        rd_done_i = 1'b0;
        wr_done_i = 1'b0;
        tick();
        total++;
        if ({rd_start_o, wr_start_o} !== 2'b00)
            $display("FAIL single_pulse_width: got %b want 00", {rd_start_o, wr_start_o});
        else passed++;
        repeat (9) tick();
        total++;
        if (irq_o !== 1'b0 || busy_o !== 1'b1 || cmpl_cnt_o !== 16'd0 || desc_cnt_o !== 3'd1)
            $display("FAIL single_running: got irq=%b busy=%b cmpl=%0d cnt=%0d want 0/1/0/1",
                     irq_o, busy_o, cmpl_cnt_o, desc_cnt_o);
        else passed++;
        rd_done_i = 1'b1;
        wr_done_i = 1'b1;
        for (n = 0; n < 10 && !irq_o; n++) tick();
        exp_cmpl++;
        total++;
        if (irq_o !== 1'b1 || cmpl_cnt_o !== 16'(exp_cmpl) || desc_cnt_o !== 3'd0 || busy_o !== 1'b0)
            $display("FAIL single_retire: got irq=%b cmpl=%0d cnt=%0d busy=%b want 1/%0d/0/0",
                     irq_o, cmpl_cnt_o, desc_cnt_o, busy_o, exp_cmpl);
        else passed++;
        total++;
        if (rd_cmd_o !== 48'h00001000_0100)
            $display("FAIL single_cmd_hold: got %h want 000010000100", rd_cmd_o);
        else passed++;
        clear_irq();
        total++;
        if (irq_o !== 1'b0) $display("FAIL single_irq_clr: got %b want 0", irq_o);
        else passed++;
    endtask

    task automatic test_order_skew();
        int n, early;
        logic [47:0] exp_cmd;
        rd_done_i = 1'b0;
        wr_done_i = 1'b0;
        for (int i = 0; i < 3; i++) push(32'h3000 + 32'(i * 16), 32'h9000 + 32'(i * 16), 16'(16'h40 * (i + 1)));
        total++;
        if (desc_cnt_o !== 3'd3 || rd_start_o !== 1'b0)
            $display("FAIL skew_queued: got cnt=%0d start=%b want 3/0", desc_cnt_o, rd_start_o);
        else passed++;
        rd_done_i = 1'b1;
        wr_done_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_cmd = {32'h3000 + 32'(i * 16), 16'(16'h40 * (i + 1))};
            for (n = 0; n < 10 && !rd_start_o; n++) tick();
            total++;
            if (rd_start_o !== 1'b1 || rd_cmd_o !== exp_cmd)
                $display("FAIL skew_order%0d: got start=%b cmd=%h want 1/%h", i, rd_start_o, rd_cmd_o, exp_cmd);
            else passed++;
            rd_done_i = 1'b0;
            wr_done_i = 1'b0;
            repeat (5) tick();
            rd_done_i = 1'b1;
            early = 0;
            repeat (20) begin
                tick();
                if (rd_start_o || wr_start_o || cmpl_cnt_o !== 16'(exp_cmpl)) early++;
            end
            total++;
            if (early !== 0) $display("FAIL skew_wait%0d: got %0d early events want 0", i, early);
            else passed++;
            wr_done_i = 1'b1;
            exp_cmpl++;
            for (n = 0; n < 10 && cmpl_cnt_o !== 16'(exp_cmpl); n++) tick();
            total++;
            if (cmpl_cnt_o !== 16'(exp_cmpl))
                $display("FAIL skew_retire%0d: got cmpl=%0d want %0d", i, cmpl_cnt_o, exp_cmpl);
            else passed++;
        end
        total++;
        if (desc_cnt_o !== 3'd0 || irq_o !== 1'b1)
            $display("FAIL skew_end: got cnt=%0d irq=%b want 0/1", desc_cnt_o, irq_o);
        else passed++;
        clear_irq();
    endtask

    task automatic test_overflow();
        int n, starts;
        rd_done_i = 1'b0;
        wr_done_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push(32'h2000 + 32'(i), 32'hA000 + 32'(i), 16'h0010);
            if (i == 3) begin
                total++;
                if (desc_full_o !== 1'b1 || desc_cnt_o !== 3'd4 || ovf_o !== 1'b0)
                    $display("FAIL ovf_full: got full=%b cnt=%0d ovf=%b want 1/4/0", desc_full_o, desc_cnt_o, ovf_o);
                else passed++;
            end
        end
        total++;
        if (desc_full_o !== 1'b1 || desc_cnt_o !== 3'd4 || ovf_o !== 1'b1)
            $display("FAIL ovf_drop: got full=%b cnt=%0d ovf=%b want 1/4/1", desc_full_o, desc_cnt_o, ovf_o);
        else passed++;
        clear_irq();
        total++;
        if (ovf_o !== 1'b0) $display("FAIL ovf_clr: got %b want 0", ovf_o);
        else passed++;
        rd_done_i = 1'b1;
        wr_done_i = 1'b1;
        starts = 0;
        for (n = 0; n < 60 && busy_o; n++) begin
            tick();
            if (rd_start_o) starts++;
        end
        exp_cmpl += 4;
        total++;
        if (starts !== 4 || busy_o !== 1'b0 || cmpl_cnt_o !== 16'(exp_cmpl))
            $display("FAIL ovf_drain: got starts=%0d busy=%b cmpl=%0d want 4/0/%0d", starts, busy_o, cmpl_cnt_o, exp_cmpl);
        else passed++;
        total++;
        if (rd_cmd_o !== {32'h2003, 16'h0010})
            $display("FAIL ovf_last: got %h want %h", rd_cmd_o, {32'h2003, 16'h0010});
        else passed++;
        clear_irq();
    endtask

    task automatic test_zero_len();
        int n, starts;
        rd_done_i = 1'b1;
        wr_done_i = 1'b1;
        push(32'hAAAA, 32'hBBBB, 16'h0000);
        starts = 0;
        repeat (10) begin
            tick();
            if (rd_start_o || wr_start_o) starts++;
        end
        exp_cmpl++;
        total++;
        if (starts !== 0 || cmpl_cnt_o !== 16'(exp_cmpl) || irq_o !== 1'b1 || busy_o !== 1'b0)
            $display("FAIL zero_retire: got starts=%0d cmpl=%0d irq=%b busy=%b want 0/%0d/1/0",
                     starts, cmpl_cnt_o, irq_o, busy_o, exp_cmpl);
        else passed++;
        total++;
        if (rd_cmd_o !== {32'hAAAA, 16'h0} || wr_cmd_o !== {32'hBBBB, 16'h0})
            $display("FAIL zero_cmd: got rd=%h wr=%h", rd_cmd_o, wr_cmd_o);
        else passed++;
        clear_irq();
        push(32'hC000, 32'hD000, 16'h0103);
        for (n = 0; n < 10 && !rd_start_o; n++) tick();
        total++;
        if (rd_start_o !== 1'b1 || rd_cmd_o !== {32'hC000, 16'h0100} || wr_cmd_o !== {32'hD000, 16'h0100})
            $display("FAIL mask_cmd: got start=%b rd=%h wr=%h want 1/0000c0000100/0000d0000100",
                     rd_start_o, rd_cmd_o, wr_cmd_o);
        else passed++;
        for (n = 0; n < 20 && busy_o; n++) tick();
        exp_cmpl++;
        total++;
        if (cmpl_cnt_o !== 16'(exp_cmpl) || busy_o !== 1'b0)
            $display("FAIL mask_retire: got cmpl=%0d busy=%b want %0d/0", cmpl_cnt_o, busy_o, exp_cmpl);
        else passed++;
        clear_irq();
    endtask

`ifdef SGDMAC_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int n, starts;
        rd_done_i = 1'b1;
        wr_done_i = 1'b1;
        push(32'hE000, 32'hF000, 16'h0040);
        for (n = 0; n < 10 && !rd_start_o; n++) tick();
        rd_done_i = 1'b0;
        for (n = 0; n < 40 && !err_o; n++) tick();
        total++;
        if (err_o !== 1'b1 || n !== 18)
            $display("FAIL timeout_err: got err=%b after %0d cycles want 1 after 18", err_o, n);
        else passed++;
        rd_done_i = 1'b1;
        push(32'hE100, 32'hF100, 16'h0040);
        starts = 0;
        repeat (10) begin
            tick();
            if (rd_start_o) starts++;
        end
        total++;
        if (starts !== 0 || desc_cnt_o !== 3'd2 || err_o !== 1'b1)
            $display("FAIL timeout_frozen: got starts=%0d cnt=%0d err=%b want 0/2/1", starts, desc_cnt_o, err_o);
        else passed++;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_cmpl = 0;
        check_all_zero("timeout_rst");
    endtask
`endif

    task automatic test_reset_midrun();
        int n;
        rd_done_i = 1'b1;
        wr_done_i = 1'b1;
        push(32'h5000, 32'h6000, 16'h0020);
        for (n = 0; n < 10 && !rd_start_o; n++) tick();
        rd_done_i = 1'b0;
        wr_done_i = 1'b0;
        repeat (4) tick();
        total++;
        if (busy_o !== 1'b1) $display("FAIL midrun_busy: got %b want 1", busy_o);
        else passed++;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        rd_done_i = 1'b1;
        wr_done_i = 1'b1;
        exp_cmpl = 0;
        check_all_zero("midrun_rst");
        push(32'h7000, 32'h7800, 16'h0008);
        for (n = 0; n < 10 && !rd_start_o; n++) tick();
        total++;
        if (rd_start_o !== 1'b1 || rd_cmd_o !== {32'h7000, 16'h0008})
            $display("FAIL midrun_recover: got start=%b cmd=%h want 1/%h", rd_start_o, rd_cmd_o, {32'h7000, 16'h0008});
        else passed++;
        for (n = 0; n < 20 && busy_o; n++) tick();
        total++;
        if (cmpl_cnt_o !== 16'd1) $display("FAIL midrun_cmpl: got %0d want 1", cmpl_cnt_o);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_order_skew();
        test_overflow();
        test_zero_len();
`ifdef SGDMAC_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_midrun();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
